// File: rtl/acq_uart_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : acq_uart_sequencer_if                                            |
// | Brief   : ADC capture / UART sequencer signal bundle with modports.        |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface acq_uart_sequencer_if #(
  parameter int N_SAMPLES = 32,
  parameter int SAMPLE_W  = 14
);
  logic [SAMPLE_W-1:0]           adc_data;
  logic                          adc_valid;
  logic [SAMPLE_W-1:0]           trig_level;
  logic                          arm;
  logic                          force_trig;
  logic                          abort;
  logic [N_SAMPLES*SAMPLE_W-1:0] waveform;
  logic                          acquire;
  logic                          bit_tick;
  logic                          busy;
  logic [2:0]                    state;
  logic [15:0]                   frames_sent;

  modport master (
    output adc_data, adc_valid, trig_level, arm, force_trig, abort,
    input  waveform, acquire, bit_tick, busy, state, frames_sent
  );

  modport slave (
    input  adc_data, adc_valid, trig_level, arm, force_trig, abort,
    output waveform, acquire, bit_tick, busy, state, frames_sent
  );
endinterface
`default_nettype wire

// File: rtl/acq_uart_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : acq_uart_sequencer                                               |
// | Brief   : Trigger/capture/transmit sequencer for the ADC-to-UART path,     |
// |           plus the serializer baud strobe. ACQ_AUTO_REARM_EN re-arms      |
// |           after HOLDOFF instead of returning to IDLE.                      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module acq_uart_sequencer #(
  parameter int N_SAMPLES     = 32,
  parameter int SAMPLE_W      = 14,
  parameter int BAUD_DIV      = 434,
  parameter int SEND_PAD      = 4,
  parameter int HOLDOFF_TICKS = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  acq_uart_sequencer_if.slave  bus
);

  localparam int          c_idx_w     = $clog2(N_SAMPLES) + 1;
  localparam int          c_addr_w    = $clog2(N_SAMPLES);
  localparam int          c_baud_w    = $clog2(BAUD_DIV);
  localparam logic [15:0] c_send_last = 16'(N_SAMPLES * 30 + SEND_PAD - 1);
  localparam logic [15:0] c_hold_last = 16'(HOLDOFF_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

`ifdef ACQ_AUTO_REARM_EN
  localparam state_t c_holdoff_exit = S_ARMED;
`else
  localparam state_t c_holdoff_exit = S_IDLE;
`endif

  state_t               r_state;
  state_t               w_next_state;
  logic [c_baud_w-1:0]  r_baud_cnt;
  logic                 w_tick;
  logic [SAMPLE_W-1:0]  r_prev_sample;
  logic                 w_trig;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_idx_w-1:0]   w_idx_next;
  logic [15:0]          r_tick_cnt;
  logic [15:0]          w_tick_cnt_next;
  logic [15:0]          r_frames_sent;
  logic                 w_frame_done;
  logic                 w_wr_en;
  logic [c_addr_w-1:0]  w_wr_addr;
  logic [SAMPLE_W-1:0]  r_wave [N_SAMPLES];

  // Free-running baud divider, independent of the sequencer state
  assign w_tick = (r_baud_cnt == c_baud_w'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + c_baud_w'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_prev_sample <= '0;
    else if (bus.adc_valid)  r_prev_sample <= bus.adc_data;
  end

  // A crossing and force_trig in the same cycle collapse into one trigger
  assign w_trig = bus.force_trig
               || (bus.adc_valid
                   && (r_prev_sample < bus.trig_level)
                   && (bus.adc_data >= bus.trig_level));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state    = r_state;
    w_wr_en         = 1'b0;
    w_wr_addr       = r_idx[c_addr_w-1:0];
    w_idx_next      = r_idx;
    w_tick_cnt_next = r_tick_cnt;
    w_frame_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.arm) w_next_state = S_ARMED;
      end
      S_ARMED: begin
        if (w_trig) begin
          w_next_state = S_CAPTURE;
          if (bus.adc_valid) begin
            w_wr_en    = 1'b1;
            w_wr_addr  = '0;
            w_idx_next = c_idx_w'(1);
          end else begin
            w_idx_next = '0;
          end
        end
      end
      S_CAPTURE: begin
        if (bus.adc_valid) begin
          w_wr_en    = 1'b1;
          w_idx_next = r_idx + c_idx_w'(1);
          if (r_idx == c_idx_w'(N_SAMPLES - 1)) begin
            w_next_state    = S_SEND;
            w_tick_cnt_next = '0;
          end
        end
      end
      S_SEND: begin
        if (w_tick) begin
          if (r_tick_cnt == c_send_last) begin
            w_next_state    = S_HOLDOFF;
            w_frame_done    = 1'b1;
            w_tick_cnt_next = '0;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 16'd1;
          end
        end
      end
      S_HOLDOFF: begin
        if (w_tick) begin
          if (r_tick_cnt == c_hold_last) begin
            w_next_state    = c_holdoff_exit;
            w_tick_cnt_next = '0;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 16'd1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    // Abort overrides everything, including a frame completing this cycle
    if (bus.abort) begin
      w_next_state    = S_IDLE;
      w_wr_en         = 1'b0;
      w_frame_done    = 1'b0;
      w_idx_next      = '0;
      w_tick_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_tick_cnt    <= '0;
      r_frames_sent <= '0;
    end else begin
      r_idx      <= w_idx_next;
      r_tick_cnt <= w_tick_cnt_next;
      if (w_frame_done) r_frames_sent <= r_frames_sent + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SAMPLES; i++) r_wave[i] <= '0;
    end else if (w_wr_en) begin
      r_wave[w_wr_addr] <= bus.adc_data;
    end
  end

  generate
    for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_pack
      assign bus.waveform[gi*SAMPLE_W +: SAMPLE_W] = r_wave[gi];
    end
  endgenerate

  assign bus.acquire     = (r_state != S_SEND);
  assign bus.bit_tick    = w_tick;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.state       = r_state;
  assign bus.frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_acq_uart_sequencer.sv
`default_nettype none
// Bench for acq_uart_sequencer: directed scenarios with a frame scoreboard
// checked by an independent monitor on every acquire release.
module tb_acq_uart_sequencer;

  localparam int N      = 32;
  localparam int W      = 14;
  localparam int BDIV   = 4;
  localparam int PAD    = 4;
  localparam int HOLD   = 8;
  localparam int FRAME  = N * 30 + PAD;

  logic clk = 1'b0;
  logic rst_n;

  acq_uart_sequencer_if #(.N_SAMPLES(N), .SAMPLE_W(W)) dut_if ();

  acq_uart_sequencer #(
    .N_SAMPLES(N), .SAMPLE_W(W), .BAUD_DIV(BDIV),
    .SEND_PAD(PAD), .HOLDOFF_TICKS(HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             ticks;
    logic [15:0]    frames;
    logic [N*W-1:0] wave;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_ticks = 0;
  logic mon_acq_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_wave(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < N; i++) begin
        if (act[i*W +: W] !== exp[i*W +: W]) begin
          $display("FAIL %s: slot %0d got %0d expected %0d", name, i, act[i*W +: W], exp[i*W +: W]);
          break;
        end
      end
    end
  endtask

  function automatic logic [N*W-1:0] ramp_wave(input int base, input int step);
    logic [N*W-1:0] w = '0;
    for (int i = 0; i < N; i++) w[i*W +: W] = W'(base + step * i);
    return w;
  endfunction

  task automatic push_exp(input int ticks, input int frames, input logic [N*W-1:0] wave);
    exp_t e;
    e.ticks  = ticks;
    e.frames = 16'(frames);
    e.wave   = wave;
    exp_q.push_back(e);
  endtask

  // Monitor: each acquire low->high release closes a frame (or an aborted one)
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_ticks    = 0;
      mon_acq_prev = 1'b1;
    end else begin
      if (!dut_if.acquire && dut_if.bit_tick) mon_ticks++;
      if (dut_if.acquire && !mon_acq_prev) begin
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_send_ticks", mon_ticks, mon_e.ticks);
          chk("frame_frames_sent", dut_if.frames_sent, mon_e.frames);
          chk_wave("frame_waveform", dut_if.waveform, mon_e.wave);
        end
        mon_ticks = 0;
      end
      mon_acq_prev = dut_if.acquire;
    end
  end

  task automatic feed_ramp(input int base, input int step, input int count);
    for (int j = 0; j < count; j++) begin
      @(negedge clk);
      dut_if.adc_data  = W'(base + step * j);
      dut_if.adc_valid = 1'b1;
    end
    @(negedge clk);
    dut_if.adc_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    @(negedge clk); dut_if.arm = 1'b1;
    @(negedge clk); dut_if.arm = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (dut_if.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, dut_if.state, s);
  endtask

  task automatic wait_send_ticks(input int target, output int ticks);
    int n = 0;
    ticks = 0;
    while (n < 5000) begin
      if (dut_if.bit_tick && !dut_if.acquire) ticks++;
      if (ticks == target) break;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_holdoff(output int ticks);
    int n = 0;
    ticks = 0;
    while (dut_if.state === 3'd4 && n < 500) begin
      if (dut_if.bit_tick) ticks++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic capture_frame(input int frames_exp, input string tag);
    int t;
    push_exp(FRAME, frames_exp, ramp_wave(1000, 5));
    pulse_arm();
    feed_ramp(990, 5, 34);
    chk({tag, "_state_send"}, dut_if.state, 3'd3);
    chk({tag, "_busy_send"}, dut_if.busy, 1'b1);
    wait_state(3'd4, 5000, {tag, "_reach_holdoff"});
    count_holdoff(t);
    chk({tag, "_holdoff_ticks"}, t, HOLD);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    logic [N*W-1:0] wave_last;
    int t;
    int bad;

    rst_n = 1'b0;
    dut_if.adc_data   = '0;
    dut_if.adc_valid  = 1'b0;
    dut_if.trig_level = W'(1000);
    dut_if.arm        = 1'b0;
    dut_if.force_trig = 1'b0;
    dut_if.abort      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_state", dut_if.state, 3'd0);
    chk("rst_acquire", dut_if.acquire, 1'b1);
    chk("rst_busy", dut_if.busy, 1'b0);
    chk("rst_bit_tick", dut_if.bit_tick, 1'b0);
    chk("rst_frames", dut_if.frames_sent, 16'd0);
    chk_wave("rst_wave", dut_if.waveform, '0);

    // Divider: one tick every 4 cycles, in the 4th cycle after release
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      pat[k-1] = dut_if.bit_tick;
    end
    chk("tick_pattern", {20'd0, pat}, 32'h444);

    // Rising crossing capture, full frame, holdoff
    capture_frame(1, "cross");
    wave_last = ramp_wave(1000, 5);
`ifdef ACQ_AUTO_REARM_EN
    chk("cross_after_holdoff", dut_if.state, 3'd1);
`else
    chk("cross_after_holdoff", dut_if.state, 3'd0);
`endif
    chk_wave("cross_wave_stable", dut_if.waveform, wave_last);

    // No trigger: level stays below threshold
    pulse_arm();
    bad = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      dut_if.adc_data  = W'(500);
      dut_if.adc_valid = 1'b1;
      if (dut_if.state !== 3'd1 || dut_if.acquire !== 1'b1) bad++;
    end
    @(negedge clk);
    dut_if.adc_valid = 1'b0;
    chk("notrig_bad_cycles", bad, 0);
    chk("notrig_state", dut_if.state, 3'd1);
    chk_wave("notrig_wave", dut_if.waveform, wave_last);

    // force_trig without valid, then 0..31 fill slots in order; abort at tick 100
    push_exp(100, 1, ramp_wave(0, 1));
    @(negedge clk);
    dut_if.force_trig = 1'b1;
    @(negedge clk);
    dut_if.force_trig = 1'b0;
    chk("force_state_capture", dut_if.state, 3'd2);
    feed_ramp(0, 1, 32);
    chk("force_state_send", dut_if.state, 3'd3);
    wait_send_ticks(100, t);
    chk("abort_tick_reached", t, 100);
    dut_if.abort = 1'b1;
    @(negedge clk);
    dut_if.abort = 1'b0;
    chk("abort_state", dut_if.state, 3'd0);
    chk("abort_acquire", dut_if.acquire, 1'b1);
    chk("abort_frames", dut_if.frames_sent, 16'd1);
    chk_wave("abort_wave_kept", dut_if.waveform, ramp_wave(0, 1));

    // Asynchronous reset in the middle of CAPTURE
    pulse_arm();
    @(negedge clk);
    dut_if.force_trig = 1'b1;
    dut_if.adc_data   = W'(7);
    dut_if.adc_valid  = 1'b1;
    @(negedge clk);
    dut_if.force_trig = 1'b0;
    dut_if.adc_data   = W'(8);
    @(negedge clk);
    dut_if.adc_data   = W'(9);
    chk("midcap_state", dut_if.state, 3'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", dut_if.state, 3'd0);
    chk("midrst_acquire", dut_if.acquire, 1'b1);
    chk("midrst_busy", dut_if.busy, 1'b0);
    chk("midrst_tick", dut_if.bit_tick, 1'b0);
    chk("midrst_frames", dut_if.frames_sent, 16'd0);
    chk_wave("midrst_wave", dut_if.waveform, '0);
    @(negedge clk);
    dut_if.adc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // arm during SEND is ignored
    push_exp(FRAME, 1, ramp_wave(1000, 5));
    pulse_arm();
    feed_ramp(990, 5, 34);
    chk("ign_state_send", dut_if.state, 3'd3);
    wait_send_ticks(10, t);
    pulse_arm();
    chk("ign_still_send", dut_if.state, 3'd3);
    wait_state(3'd4, 5000, "ign_reach_holdoff");
    count_holdoff(t);
    chk("ign_holdoff_ticks", t, HOLD);
`ifdef ACQ_AUTO_REARM_EN
    chk("ign_rearmed", dut_if.state, 3'd1);
    @(negedge clk);
    dut_if.adc_data  = '0;
    dut_if.adc_valid = 1'b1;
    push_exp(FRAME, 2, ramp_wave(1000, 5));
    feed_ramp(990, 5, 34);
    chk("rearm_state_send", dut_if.state, 3'd3);
    wait_state(3'd4, 5000, "rearm_reach_holdoff");
    count_holdoff(t);
    chk("rearm_holdoff_ticks", t, HOLD);
    chk("rearm_frames", dut_if.frames_sent, 16'd2);
    chk("rearm_state_armed", dut_if.state, 3'd1);
`else
    chk("ign_idle", dut_if.state, 3'd0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dut_if.state !== 3'd0) bad++;
    end
    chk("ign_not_queued", bad, 0);
    chk("ign_frames", dut_if.frames_sent, 16'd1);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
